// File: rtl/sensor_packet_framer.sv
// Drains the sensor sample FIFO and frames samples into SYNC/LEN/payload/checksum byte packets.
// Define PKT_CRC8_EN to replace the additive checksum with CRC-8 (poly 0x07).
module sensor_packet_framer #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          ADDR_WIDTH     = 3,
  parameter int          BURST_LEN      = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic [15:0]           pkt_count
);
  localparam int BPS = DATA_WIDTH / 8;
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;

  typedef enum logic [2:0] {
    IDLE, HDR_SYNC, HDR_LEN, FETCH, WAIT_DATA, SEND, CHECKSUM
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         len, remaining;
  logic [TW-1:0]         timer;
  logic [7:0]            csum;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         byte_idx;
  logic                  xfer, full_start, part_start, last_byte;

  function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
`ifdef PKT_CRC8_EN
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
`else
    return c + b;
`endif
  endfunction

  assign xfer       = tx_valid && tx_ready;
  assign full_start = enable && (fifo_count >= CW'(BURST_LEN));
  assign part_start = enable && !fifo_empty && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_byte  = (byte_idx == BW'(BPS - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx   = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:      if (full_start || part_start) state_nx = HDR_SYNC;
      HDR_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_nx = HDR_LEN;
      end
      HDR_LEN: begin
        tx_valid = 1'b1;
        tx_data  = 8'(len);
        if (tx_ready) state_nx = FETCH;
      end
      // Sole reader with len <= occupancy, so the empty guard is only a safety net.
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nx   = WAIT_DATA;
        end
      end
      WAIT_DATA: state_nx = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[DATA_WIDTH-1 -: 8];
        if (tx_ready && last_byte)
          state_nx = (remaining == CW'(1)) ? CHECKSUM : FETCH;
      end
      CHECKSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        tx_last  = 1'b1;
        if (tx_ready) state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      remaining <= '0;
      timer     <= '0;
      csum      <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (full_start || part_start) begin
            timer     <= '0;
            len       <= full_start ? CW'(BURST_LEN) : fifo_count;
            remaining <= full_start ? CW'(BURST_LEN) : fifo_count;
            csum      <= '0;
            byte_idx  <= '0;
          end else begin
            timer <= (enable && !fifo_empty) ? timer + TW'(1) : '0;
          end
        end
        HDR_LEN:   if (xfer) csum <= csum_upd(csum, tx_data);
        WAIT_DATA: begin
          shreg    <= fifo_rd_data;
          byte_idx <= '0;
        end
        SEND: begin
          if (xfer) begin
            csum  <= csum_upd(csum, tx_data);
            shreg <= shreg << 8;
            if (last_byte) begin
              byte_idx  <= '0;
              remaining <= remaining - CW'(1);
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        CHECKSUM:  if (xfer) pkt_count <= pkt_count + 16'd1;
        default: ;
      endcase
    end
  end
endmodule
